// File: rtl/conv_window_accumulator.sv
// Accumulates TERMS unsigned partial sums from the ripple adder into one output pixel.
// The window sum and a saturated pixel are held on a valid/ready output until consumed.
module conv_window_accumulator #(
  parameter int TERMS = 9,
  parameter int IN_W  = 9,
  parameter int ACC_W = 13,
  parameter int PIX_W = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [PIX_W-1:0] pix_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err_frame,
  output logic [CNT_W-1:0] term_cnt
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [ACC_W-1:0] PIX_MAX  = ACC_W'((2 ** PIX_W) - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TERMS - 1);

  function automatic logic [PIX_W-1:0] sat_pix(input logic [ACC_W-1:0] v);
    if (v > PIX_MAX) return '1;
    else             return v[PIX_W-1:0];
  endfunction

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum_next;
  logic             cnt_full;
  logic             in_xfer;

  always_comb begin
    sum_next = acc + {{(ACC_W-IN_W){1'b0}}, in_data};
    cnt_full = (term_cnt == LAST_CNT);
    in_xfer  = in_valid && in_ready;
  end

  assign in_ready = (state == ACCUM);

  // A window closes on the expected last count or on an early in_last; any
  // disagreement between the two is a framing error but still emits a pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      term_cnt  <= '0;
      out_valid <= 1'b0;
      acc_out   <= '0;
      pix_out   <= '0;
      err_frame <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_xfer) begin
            if (in_last != cnt_full) err_frame <= 1'b1;
            if (cnt_full || in_last) begin
              acc_out   <= sum_next;
              pix_out   <= sat_pix(sum_next);
              acc       <= '0;
              term_cnt  <= '0;
              out_valid <= 1'b1;
              state     <= HOLD;
            end else begin
              acc      <= sum_next;
              term_cnt <= term_cnt + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
